// File: rtl/interrupt_controller.sv
// Interrupt sequencer for the 12-bit CPU: edge-latches IRQ lines, arbitrates by lowest index,
// and drives the context save / PC vector / context restore handshake with one nesting level.
module interrupt_controller #(
   parameter int          N_IRQ      = 4,
   parameter logic [11:0] VEC_BASE   = 12'h004,
   parameter int unsigned VEC_STRIDE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic [N_IRQ-1:0] irq_i,
   input  logic             gie_i,
   input  logic             mask_we_i,
   input  logic [N_IRQ-1:0] mask_i,
   input  logic             boundary_i,
   input  logic             reti_i,
   output logic             save_en_o,
   output logic             restore_o,
   output logic             pc_load_o,
   output logic [11:0]      vector_o,
   output logic [2:0]       irq_id_o,
   output logic             in_isr_o,
   output logic [N_IRQ-1:0] pending_o,
   output logic [N_IRQ-1:0] mask_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAVE   = 2'd1,
      ST_VECTOR = 2'd2,
      ST_ISR    = 2'd3
   } state_t;

   // Lowest set index wins arbitration.
   function automatic logic [2:0] lowest_index(input logic [N_IRQ-1:0] req);
      logic [2:0] idx;
      logic       found;
      idx   = 3'd0;
      found = 1'b0;
      for (int k = 0; k < N_IRQ; k++) begin
         if (req[k] && !found) begin
            idx   = 3'(k);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   state_t             state_r;
   logic [N_IRQ-1:0]   prev_r;
   logic [N_IRQ-1:0]   pending_r;
   logic [N_IRQ-1:0]   mask_r;
   logic               save_en_r;
   logic               restore_r;
   logic               pc_load_r;
   logic [11:0]        vector_r;
   logic [2:0]         irq_id_r;
   logic               in_isr_r;

   logic [N_IRQ-1:0]   rise_s;
   logic [N_IRQ-1:0]   eligible_s;
   logic [N_IRQ-1:0]   clr_s;
   logic [2:0]         winner_s;
   logic [11:0]        vec_s;

   assign rise_s     = irq_i & ~prev_r;
   assign eligible_s = pending_r & mask_r;
   assign winner_s   = lowest_index(eligible_s);
   assign vec_s      = VEC_BASE + (12'(irq_id_r) * 12'(VEC_STRIDE));

   // Clear the serviced source as the FSM leaves SAVE (pending bit drops with pc_load_o).
   always_comb begin
      for (int k = 0; k < N_IRQ; k++) begin
         if (clk_en && (state_r == ST_SAVE) && (irq_id_r == 3'(k))) begin
            clr_s[k] = 1'b1;
         end else begin
            clr_s[k] = 1'b0;
         end
      end
   end

   // Edge history, pending and mask run every clk so edges and mask writes survive clk_en=0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_r    <= {N_IRQ{1'b0}};
         pending_r <= {N_IRQ{1'b0}};
         mask_r    <= {N_IRQ{1'b0}};
      end else begin
         prev_r    <= irq_i;
         pending_r <= (pending_r & ~clr_s) | rise_s;
         if (mask_we_i) begin
            mask_r <= mask_i;
         end
      end
   end

   // Sequencing FSM with registered Moore outputs; the winner is committed on IDLE exit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         save_en_r <= 1'b0;
         restore_r <= 1'b0;
         pc_load_r <= 1'b0;
         vector_r  <= 12'h000;
         irq_id_r  <= 3'd0;
         in_isr_r  <= 1'b0;
      end else if (clk_en) begin
         save_en_r <= 1'b0;
         restore_r <= 1'b0;
         pc_load_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (boundary_i && gie_i && (|eligible_s)) begin
                  state_r   <= ST_SAVE;
                  save_en_r <= 1'b1;
                  irq_id_r  <= winner_s;
               end
            end
            ST_SAVE: begin
               state_r   <= ST_VECTOR;
               pc_load_r <= 1'b1;
               vector_r  <= vec_s;
            end
            ST_VECTOR: begin
               state_r  <= ST_ISR;
               in_isr_r <= 1'b1;
            end
            ST_ISR: begin
               if (reti_i) begin
                  state_r   <= ST_IDLE;
                  in_isr_r  <= 1'b0;
                  restore_r <= 1'b1;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               in_isr_r <= 1'b0;
            end
         endcase
      end
   end

   assign save_en_o = save_en_r;
   assign restore_o = restore_r;
   assign pc_load_o = pc_load_r;
   assign vector_o  = vector_r;
   assign irq_id_o  = irq_id_r;
   assign in_isr_o  = in_isr_r;
   assign pending_o = pending_r;
   assign mask_o    = mask_r;

endmodule
